sat_var_sched: RTL and testbench

Variable-update scheduler that sits directly upstream of the variable processing element array. It owns the 60-bit variable assignment bus V that is broadcast to every VPE. It sweeps the variables round-robin, pulsing one VUL_EN at a time and capturing each VPE's VI_BUS result back into V. After each sweep it samples the array-corner SATISFY to decide solved, timeout or next sweep.

---
 rtl/sat_pkg.sv | 16 +
 rtl/sat_onehot_dec.sv | 19 +
 rtl/sat_var_sched.sv | 147 ++++++++++++++
 tb/tb_sat_var_sched.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/sat_pkg.sv
// Shared types and default sizing for the SAT variable-update scheduler.
package sat_pkg;

    localparam int unsigned SatNumVar = 60;
    localparam int unsigned SatIterW  = 16;
    localparam int unsigned SatLat    = 4;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StUpd,
        StCapt,
        StFin
    } sat_state_e;

endpackage

// File: rtl/sat_onehot_dec.sv
// Index to one-hot decoder with enable; out-of-range indices decode to all zeros.
module sat_onehot_dec #(
    parameter int unsigned N    = 60,
    parameter int unsigned IdxW = 6
) (
    input  logic [IdxW-1:0] idx_i,
    input  logic            en_i,
    output logic [N-1:0]    onehot_o
);

    // Set exactly the addressed bit when enabled.
    always_comb begin
        onehot_o = '0;
        if (en_i && (32'(idx_i) < N)) begin
            onehot_o[idx_i] = 1'b1;
        end
    end

endmodule

// File: rtl/sat_var_sched.sv
// Round-robin variable-update scheduler: owns the assignment bus V, pulses one
// update enable per variable, captures VPE results, and decides solved/timeout
// after each sweep once the SATISFY chain has settled.
module sat_var_sched
    import sat_pkg::*;
#(
    parameter int unsigned NUM_VAR = SatNumVar,
    parameter int unsigned ITER_W  = SatIterW,
    parameter int unsigned SAT_LAT = SatLat
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [ITER_W-1:0]  max_iter_i,
    input  logic [NUM_VAR-1:0] v_init_i,
    input  logic [NUM_VAR-1:0] vi_bus_i,
    input  logic               satisfy_i,
    output logic [NUM_VAR-1:0] v_o,
    output logic [NUM_VAR-1:0] vul_en_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               solved_o,
    output logic [ITER_W-1:0]  iter_cnt_o
);

    localparam int unsigned IdxW  = (NUM_VAR > 1) ? $clog2(NUM_VAR) : 1;
    localparam int unsigned WaitW = (SAT_LAT > 1) ? $clog2(SAT_LAT) : 1;

    localparam logic [WaitW-1:0] WaitInit = WaitW'(SAT_LAT - 1);
    localparam logic [IdxW-1:0]  IdxLast  = IdxW'(NUM_VAR - 1);

    sat_state_e         state_q;
    logic [WaitW-1:0]   wait_q;
    logic [IdxW-1:0]    idx_q;
    logic [ITER_W-1:0]  max_iter_q;
    logic [ITER_W-1:0]  iter_cnt_q;
    logic [NUM_VAR-1:0] v_q;
    logic [NUM_VAR-1:0] vul_en_q;
    logic               busy_q;
    logic               done_q;
    logic               solved_q;

    logic               check_last;
    logic               sweep_end;
    logic               upd_next;
    logic [IdxW-1:0]    upd_idx;
    logic [NUM_VAR-1:0] upd_onehot;

    // Decode whether the next cycle is an UPD cycle and which variable it targets,
    // so the enable can be registered on the way into UPD.
    always_comb begin
        check_last = (state_q == StCheck) && (wait_q == '0);
        sweep_end  = (state_q == StCapt) && (idx_q == IdxLast);
        upd_next   = (check_last && !satisfy_i && (iter_cnt_q != max_iter_q)) ||
                     ((state_q == StCapt) && (idx_q != IdxLast));
        upd_idx    = (state_q == StCapt) ? idx_q + IdxW'(1) : '0;
    end

    sat_onehot_dec #(
        .N    (NUM_VAR),
        .IdxW (IdxW)
    ) u_dec (
        .idx_i    (upd_idx),
        .en_i     (upd_next),
        .onehot_o (upd_onehot)
    );

    // Scheduler FSM with its counters, V register and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            wait_q     <= '0;
            idx_q      <= '0;
            max_iter_q <= '0;
            iter_cnt_q <= '0;
            v_q        <= '0;
            vul_en_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            solved_q   <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            vul_en_q <= upd_onehot;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        v_q        <= v_init_i;
                        iter_cnt_q <= '0;
                        solved_q   <= 1'b0;
                        max_iter_q <= max_iter_i;
                        wait_q     <= WaitInit;
                        idx_q      <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= StCheck;
                    end
                end
                StCheck: begin
                    if (wait_q != '0) begin
                        wait_q <= wait_q - WaitW'(1);
                    end else if (satisfy_i) begin
                        solved_q <= 1'b1;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= StFin;
                    end else if (iter_cnt_q == max_iter_q) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StFin;
                    end else begin
                        idx_q   <= '0;
                        state_q <= StUpd;
                    end
                end
                StUpd: begin
                    state_q <= StCapt;
                end
                StCapt: begin
                    v_q[idx_q] <= vi_bus_i[idx_q];
                    if (sweep_end) begin
                        // Saturate rather than wrap so a long run never aliases to zero.
                        iter_cnt_q <= (iter_cnt_q == '1) ? iter_cnt_q
                                                         : iter_cnt_q + ITER_W'(1);
                        wait_q     <= WaitInit;
                        state_q    <= StCheck;
                    end else begin
                        idx_q   <= idx_q + IdxW'(1);
                        state_q <= StUpd;
                    end
                end
                StFin: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign v_o        = v_q;
    assign vul_en_o   = vul_en_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign solved_o   = solved_q;
    assign iter_cnt_o = iter_cnt_q;

endmodule

// File: tb/tb_sat_var_sched.sv
// Directed bench for sat_var_sched: table of whole runs plus reset and
// start-while-busy sequences.
module tb_sat_var_sched;

    localparam int NV     = 60;
    localparam int IW     = 16;
    localparam int LAT    = 4;
    localparam int SWEEP  = 2 * NV + LAT;
    localparam int BOUND  = 2000;

    localparam logic [NV-1:0] PA = 60'h0123_4567_89AB_CDE;
    localparam logic [NV-1:0] PB = 60'hFED_CBA9_8765_4321;
    localparam logic [NV-1:0] PC = 60'hAAA_AAAA_5555_5555;

    logic          clk;
    logic          rst;
    logic          start;
    logic [IW-1:0] max_iter;
    logic [NV-1:0] v_init;
    logic [NV-1:0] vi_bus;
    logic          satisfy;
    logic [NV-1:0] v;
    logic [NV-1:0] vul_en;
    logic          busy;
    logic          done;
    logic          solved;
    logic [IW-1:0] iter_cnt;

    // 0: never, 1: always, 2: when V equals target, 3: only while an enable is up
    int            sat_mode;
    logic [NV-1:0] target;

    int n_assert;
    int n_fail;

    assign satisfy = (sat_mode == 1) ||
                     ((sat_mode == 2) && (v == target)) ||
                     ((sat_mode == 3) && (|vul_en));

    sat_var_sched #(
        .NUM_VAR (NV),
        .ITER_W  (IW),
        .SAT_LAT (LAT)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .max_iter_i (max_iter),
        .v_init_i   (v_init),
        .vi_bus_i   (vi_bus),
        .satisfy_i  (satisfy),
        .v_o        (v),
        .vul_en_o   (vul_en),
        .busy_o     (busy),
        .done_o     (done),
        .solved_o   (solved),
        .iter_cnt_o (iter_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NV-1:0] v_init;
        logic [NV-1:0] vi;
        logic [IW-1:0] max_iter;
        int            sat_mode;
        logic [NV-1:0] target;
        bit            poke;
        logic          exp_solved;
        logic [IW-1:0] exp_iter;
        int            exp_k;
        logic [NV-1:0] exp_v;
    } row_t;

    row_t rows[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one complete run and check timing, enable walk and final result.
    task automatic run_row(input int id, input row_t r);
        int            n;
        int            p;
        int            idx;
        logic [NV-1:0] one;
        one = 60'd1;
        @(negedge clk);
        sat_mode = r.sat_mode;
        target   = r.target;
        vi_bus   = r.vi;
        v_init   = r.v_init;
        max_iter = r.max_iter;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check($sformatf("row%0d busy_after_start", id), 64'(busy), 64'd1);
        n = 0;
        p = 0;
        while (!done && n < BOUND) begin
            @(posedge clk);
            #1;
            n++;
            if (r.poke && (n == 7 || n == 130)) begin
                start    = 1'b1;
                v_init   = ~r.v_init;
                max_iter = '0;
            end else begin
                start    = 1'b0;
                v_init   = r.v_init;
                max_iter = r.max_iter;
            end
            if (vul_en != '0) begin
                idx = p % NV;
                check($sformatf("row%0d vul_en p%0d", id, p), 64'(vul_en), 64'(one << idx));
                check($sformatf("row%0d vul_en_time p%0d", id, p), 64'(n),
                      64'(LAT + (p / NV) * SWEEP + 2 * idx));
                p++;
            end
        end
        start = 1'b0;
        check($sformatf("row%0d done_seen", id), 64'(done), 64'd1);
        // START and DONE cycles excluded from n.
        check($sformatf("row%0d done_cycle", id), 64'(n), 64'(LAT + r.exp_k * SWEEP));
        check($sformatf("row%0d busy_in_fin", id), 64'(busy), 64'd0);
        check($sformatf("row%0d solved", id), 64'(solved), 64'(r.exp_solved));
        check($sformatf("row%0d iter_cnt", id), 64'(iter_cnt), 64'(r.exp_iter));
        check($sformatf("row%0d v", id), 64'(v), 64'(r.exp_v));
        check($sformatf("row%0d pulses", id), 64'(p), 64'(r.exp_k * NV));
        @(posedge clk);
        #1;
        check($sformatf("row%0d done_pulse", id), 64'(done), 64'd0);
        check($sformatf("row%0d solved_hold", id), 64'(solved), 64'(r.exp_solved));
        check($sformatf("row%0d iter_hold", id), 64'(iter_cnt), 64'(r.exp_iter));
    endtask

    initial begin
        int n;
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        max_iter = '0;
        v_init   = '0;
        vi_bus   = '0;
        sat_mode = 0;
        target   = '0;

        rows[0] = '{60'h1, PB, 16'd5, 1, '0, 1'b0, 1'b1, 16'd0, 0, 60'h1};
        rows[1] = '{PA, ~PA, 16'd5, 2, ~PA, 1'b0, 1'b1, 16'd1, 1, ~PA};
        rows[2] = '{PA, PB, 16'd3, 0, '0, 1'b0, 1'b0, 16'd3, 3, PB};
        rows[3] = '{PB, PA, 16'd0, 0, '0, 1'b0, 1'b0, 16'd0, 0, PB};
        rows[4] = '{PC, PA, 16'd5, 2, PC, 1'b0, 1'b1, 16'd0, 0, PC};
        rows[5] = '{PC, PB, 16'd1, 3, '0, 1'b0, 1'b0, 16'd1, 1, PB};
        rows[6] = '{PB, PC, 16'd2, 0, '0, 1'b1, 1'b0, 16'd2, 2, PC};

        repeat (3) @(posedge clk);
        #1;
        check("reset v", 64'(v), 64'd0);
        check("reset vul_en", 64'(vul_en), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset solved", 64'(solved), 64'd0);
        check("reset iter_cnt", 64'(iter_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_row(i, rows[i]);
        end

        // Reset mid-sweep when the enable reaches variable 17.
        @(negedge clk);
        sat_mode = 0;
        vi_bus   = ~PA;
        v_init   = PA;
        max_iter = 16'd5;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (!vul_en[17] && n < BOUND) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("midrst reached idx17", 64'(vul_en[17]), 64'd1);
        rst = 1'b1;
        #1;
        check("midrst v", 64'(v), 64'd0);
        check("midrst vul_en", 64'(vul_en), 64'd0);
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst iter_cnt", 64'(iter_cnt), 64'd0);
        @(posedge clk);
        #1;
        check("midrst held v", 64'(v), 64'd0);
        check("midrst held vul_en", 64'(vul_en), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("postrst idle busy", 64'(busy), 64'd0);
        check("postrst v not reloaded", 64'(v), 64'd0);
        run_row(7, rows[1]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
